// File: rtl/psum_accumulator_pkg.sv
// Shared partial-sum definitions for the fusion unit
// and the psum accumulator.
package psum_pkg;

  localparam int PSUM_W = 18;
  localparam int LANE_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic is_packed(
    input logic [2:0] weight_width
  );
    return weight_width[1] | weight_width[0];
  endfunction

endpackage

// File: rtl/psum_accumulator_unpack.sv
// Splits one psum beat into two extended lanes
// (packed) or one extended total (full).
module psum_unpack
  import psum_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              packed_mode,
  input  logic              is_signed,
  output logic [ACC_W-1:0]  lane0,
  output logic [ACC_W-1:0]  lane1
);

  logic [LANE_W-1:0] lo;
  logic [LANE_W-1:0] hi;
  logic              lo_sx;
  logic              hi_sx;
  logic              full_sx;

  assign lo      = psum_in[LANE_W-1:0];
  assign hi      = psum_in[PSUM_W-1:LANE_W];
  assign lo_sx   = is_signed & lo[LANE_W-1];
  assign hi_sx   = is_signed & hi[LANE_W-1];
  assign full_sx = is_signed & psum_in[PSUM_W-1];

  always_comb begin
    if (packed_mode) begin
      lane0 = {{(ACC_W-LANE_W){lo_sx}}, lo};
      lane1 = {{(ACC_W-LANE_W){hi_sx}}, hi};
    end else begin
      lane0 = {{(ACC_W-PSUM_W){full_sx}}, psum_in};
      lane1 = '0;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates psum beats into per-group lane totals
// and presents them on a valid/ready port.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cfg_weight_width,
  input  logic              cfg_signed,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic [ACC_W-1:0]  acc_out0,
  output logic [ACC_W-1:0]  acc_out1,
  output logic              acc_packed,
  output logic              acc_valid,
  input  logic              acc_ready
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               packed_q, packed_d;
  logic               signed_q, signed_d;
  logic [ACC_W-1:0]   acc0_q, acc0_d;
  logic [ACC_W-1:0]   acc1_q, acc1_d;
  logic               valid_q, valid_d;

  logic               beat;
  logic               in_idle;
  logic               use_packed;
  logic               use_signed;
  logic [LEN_W-1:0]   eff_len;
  logic [LEN_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   lane0;
  logic [ACC_W-1:0]   lane1;

  assign psum_ready = (state_q != HOLD);
  assign beat       = psum_valid & psum_ready;
  assign in_idle    = (state_q == IDLE);
  assign eff_len    = (acc_len == '0) ? LEN_W'(1) : acc_len;
  assign cnt_inc    = cnt_q + LEN_W'(1);

  // Live config only steers the first beat of a group.
  assign use_packed = in_idle ? is_packed(cfg_weight_width)
                              : packed_q;
  assign use_signed = in_idle ? cfg_signed : signed_q;

  psum_unpack #(
    .ACC_W (ACC_W)
  ) u_unpack (
    .psum_in     (psum_in),
    .packed_mode (use_packed),
    .is_signed   (use_signed),
    .lane0       (lane0),
    .lane1       (lane1)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    packed_d = packed_q;
    signed_d = signed_q;
    acc0_d   = acc0_q;
    acc1_d   = acc1_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          packed_d = use_packed;
          signed_d = use_signed;
          len_d    = eff_len;
          acc0_d   = lane0;
          acc1_d   = lane1;
          cnt_d    = LEN_W'(1);
          if (eff_len == LEN_W'(1)) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          acc0_d = acc0_q + lane0;
          acc1_d = acc1_q + lane1;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (acc_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      packed_q <= 1'b0;
      signed_q <= 1'b0;
      acc0_q   <= '0;
      acc1_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      packed_q <= packed_d;
      signed_q <= signed_d;
      acc0_q   <= acc0_d;
      acc1_q   <= acc1_d;
      valid_q  <= valid_d;
    end
  end

  assign acc_out0   = acc0_q;
  assign acc_out1   = acc1_q;
  assign acc_packed = packed_q;
  assign acc_valid  = valid_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator; inputs change
// and outputs are sampled on the falling edge.
module tb_psum_accumulator;

  localparam int ACC_W = 32;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       cfg_weight_width;
  logic             cfg_signed;
  logic [LEN_W-1:0] acc_len;
  logic [17:0]      psum_in;
  logic             psum_valid;
  logic             psum_ready;
  logic [ACC_W-1:0] acc_out0;
  logic [ACC_W-1:0] acc_out1;
  logic             acc_packed;
  logic             acc_valid;
  logic             acc_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  psum_accumulator #(
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_weight_width (cfg_weight_width),
    .cfg_signed       (cfg_signed),
    .acc_len          (acc_len),
    .psum_in          (psum_in),
    .psum_valid       (psum_valid),
    .psum_ready       (psum_ready),
    .acc_out0         (acc_out0),
    .acc_out1         (acc_out1),
    .acc_packed       (acc_packed),
    .acc_valid        (acc_valid),
    .acc_ready        (acc_ready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [17:0] v);
    psum_in    = v;
    psum_valid = 1'b1;
    @(negedge clk);
    psum_valid = 1'b0;
  endtask

  task automatic release_result(input string tag);
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk({tag, "_valid_drop"}, acc_valid, 1'b0);
    chk({tag, "_ready_back"}, psum_ready, 1'b1);
  endtask

  initial begin
    rst              = 1'b1;
    cfg_weight_width = 3'b000;
    cfg_signed       = 1'b0;
    acc_len          = 8'd4;
    psum_in          = '0;
    psum_valid       = 1'b0;
    acc_ready        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid",  acc_valid,  1'b0);
    chk("rst_out0",   acc_out0,   32'd0);
    chk("rst_out1",   acc_out1,   32'd0);
    chk("rst_packed", acc_packed, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",  psum_ready, 1'b1);

    // unsigned full mode, 4 beats
    send(18'd100);
    send(18'd200);
    send(18'd300);
    chk("full_valid_early", acc_valid, 1'b0);
    send(18'd400);
    chk("full_valid",  acc_valid,  1'b1);
    chk("full_out0",   acc_out0,   32'd1000);
    chk("full_out1",   acc_out1,   32'd0);
    chk("full_packed", acc_packed, 1'b0);
    chk("full_ready",  psum_ready, 1'b0);
    release_result("full");
    chk("full_keep", acc_out0, 32'd1000);

    // signed packed mode, lanes +5 and -3
    cfg_weight_width = 3'b010;
    cfg_signed       = 1'b1;
    acc_len          = 8'd3;
    send({9'h1FD, 9'h005});
    send({9'h1FD, 9'h005});
    send({9'h1FD, 9'h005});
    chk("pk_valid",  acc_valid,  1'b1);
    chk("pk_out0",   acc_out0,   32'd15);
    chk("pk_out1",   acc_out1,   32'hFFFF_FFF7);
    chk("pk_packed", acc_packed, 1'b1);
    release_result("pk");

    // backpressure with psum_valid held high
    cfg_weight_width = 3'b000;
    cfg_signed       = 1'b0;
    acc_len          = 8'd2;
    send(18'd5);
    send(18'd6);
    psum_in    = 18'd7;
    psum_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", psum_ready, 1'b0);
      chk("bp_valid", acc_valid,  1'b1);
      chk("bp_out0",  acc_out0,   32'd11);
      @(negedge clk);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk("bp_valid_drop", acc_valid,  1'b0);
    chk("bp_ready_back", psum_ready, 1'b1);
    chk("bp_out0_keep",  acc_out0,   32'd11);
    @(negedge clk);
    psum_valid = 1'b0;
    chk("bp_next_beat", acc_out0,  32'd7);
    chk("bp_next_busy", acc_valid, 1'b0);
    send(18'd1);
    chk("bp_next_out0", acc_out0, 32'd8);
    release_result("bp");

    // acc_len 0 behaves as 1; extension of max value
    acc_len = 8'd0;
    send(18'h3FFFF);
    chk("len0_valid", acc_valid, 1'b1);
    chk("len0_out0",  acc_out0,  32'd262143);
    release_result("len0");
    cfg_signed = 1'b1;
    send(18'h3FFFF);
    chk("sx_full_out0", acc_out0, 32'hFFFF_FFFF);
    chk("sx_full_out1", acc_out1, 32'd0);
    release_result("sx");
    cfg_signed = 1'b0;

    // reset in the middle of a group
    acc_len = 8'd4;
    send(18'd1);
    send(18'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", acc_valid, 1'b0);
    chk("mid_rst_out0",  acc_out0,  32'd0);
    chk("mid_rst_out1",  acc_out1,  32'd0);
    chk("mid_rst_ready", psum_ready, 1'b1);
    send(18'd1);
    send(18'd1);
    send(18'd1);
    chk("post_rst_early", acc_valid, 1'b0);
    send(18'd1);
    chk("post_rst_valid", acc_valid, 1'b1);
    chk("post_rst_out0",  acc_out0,  32'd4);
    release_result("post_rst");

    // config changes after the first beat are ignored
    cfg_weight_width = 3'b000;
    acc_len          = 8'd4;
    send(18'd1000);
    cfg_weight_width = 3'b001;
    acc_len          = 8'd2;
    send(18'd1000);
    chk("latch_len", acc_valid, 1'b0);
    send(18'd1000);
    send(18'd1000);
    chk("latch_valid",  acc_valid,  1'b1);
    chk("latch_out0",   acc_out0,   32'd4000);
    chk("latch_out1",   acc_out1,   32'd0);
    chk("latch_packed", acc_packed, 1'b0);
    release_result("latch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
